multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the R/I/J single-datapath CPU through IF/ID/EX/MEM/WB steps. It decodes the opcode and funct fields held in the datapath's IR. It drives every datapath enable and mux select, and counts retired instructions for the board display. It replaces per-instruction combinational control, so one shared ALU and one memory port serve all phases.

Parameters:
CNT_W, 32, width of retired-instruction counter
JAL_REG, 31, destination register index for jal (informational; selected via reg_dst=2)

Ports:
clk  in  1  system clock (board switch / oscillator)
rst_n  in  1  asynchronous active-low reset
run  in  1  step enable; 0 = stall in current state
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (combinational, valid in EX)
pc_write  out  1  PC load enable
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst  out  2  0=rt, 1=rd, 2=$31
mem_to_reg  out  2  0=ALU result reg, 1=MDR, 2=PC (already PC+4)
mem_write  out  1  data memory write enable
alu_src_b  out  2  0=B reg, 1=extended imm, 2=shamt
alu_op  out  4  0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 sltu,8 sll
ext_sign  out  1  1=sign-extend imm16, 0=zero-extend
state  out  3  current state, for debug LEDs
illegal  out  1  one-cycle pulse on undecodable instruction
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Values 5–7 are unreachable and go to IF.
- Supported R-type (op=0) funct codes: add 20h, sub 22h, and 24h, or 25h, xor 26h, nor 27h, slt 2Ah, sll 00h.
- Supported I-type and J opcodes: addi 08h, sltiu 0Bh, andi 0Ch, ori 0Dh, xori 0Eh, lw 23h, sw 2Bh, beq 04h, bne 05h, j 02h, jal 03h.
- Outputs are Moore/Mealy combinational on state, op, funct and zero. All write enables (pc_write, ir_write, reg_write, mem_write) are ANDed with run and rst_n.
- State transitions occur only on a rising clk edge with run=1. When run=0, state and instr_cnt hold and no pulses are emitted.
- IF: ir_write=1, pc_write=1, pc_src=0. Next state is ID.
- ID (decode):
  - j: pc_write=1, pc_src=2, done; next state IF.
  - jal: next state WB.
  - illegal op or funct: illegal=1, done, no writes; next state IF.
  - All other instructions: next state EX.
- EX, R-type and ALU-imm: alu_op from funct/op. sll uses alu_src_b=2. Imm forms use alu_src_b=1. Next state WB.
- EX, lw/sw: alu_op=add, alu_src_b=1, ext_sign=1. Next state MEM.
- EX, beq/bne: alu_op=sub, alu_src_b=0, pc_src=1. pc_write=zero for beq, ~zero for bne. Done; next state IF.
- MEM, lw: next state WB.
- MEM, sw: mem_write=1, done; next state IF.
- WB, R-type: reg_write=1, reg_dst=1, mem_to_reg=0.
- WB, ALU-imm: reg_write=1, reg_dst=0, mem_to_reg=0.
- WB, lw: reg_write=1, reg_dst=0, mem_to_reg=1.
- WB, jal: reg_write=1, reg_dst=2, mem_to_reg=2, pc_write=1, pc_src=2.
- WB always completes the instruction (done) and returns to IF.
- ext_sign: 1 for addi, sltiu, lw, sw, beq, bne; 0 for andi, ori, xori.
- Idle defaults in any state: pc_src=0, reg_dst=0, mem_to_reg=0, alu_src_b=0, alu_op=0, ext_sign=0.
- Instruction latency in cycles: j 2, beq/bne 3, jal 3, R/ALU-imm 4, sw 4, lw 5, illegal 2.
- instr_done=1 in the final cycle of each instruction, including illegal. instr_cnt increments on that edge and wraps at 2^CNT_W−1 → 0.
- Reset: asynchronous, mid-instruction allowed. While rst_n=0: state=IF, instr_cnt=0, all enables and pulses 0, selects at idle defaults. The first edge after rst_n rises with run=1 performs IF.
- Opcodes are decoded from the live IR in ID, EX, MEM and WB. IR is written only in IF, so decode is stable within an instruction.

Test Plan:
- Reset then run=1, IR=add $3,$1,$2 (op 0, funct 20h) → states 0,1,2,4,0; WB: reg_write=1, reg_dst=1; instr_cnt=1; instr_done one pulse.
- lw (op 23h) → 5-cycle sequence 0,1,2,3,4. EX: alu_src_b=1, ext_sign=1. WB: mem_to_reg=1.
- sw (op 2Bh) → MEM: mem_write=1; reg_write never 1; back to IF after 4 cycles.
- beq with zero=1 → EX: pc_write=1, pc_src=1. beq with zero=0 → pc_write=0. bne with zero=0 → pc_write=1.
- j → ID: pc_write=1, pc_src=2. jal → WB: reg_dst=2, mem_to_reg=2, pc_write=1. Latencies 2 and 3.
- op=3Fh → illegal pulse in ID, no writes, back to IF. run=0 in EX → state holds, enables 0. rst_n low in MEM → immediate state=0, instr_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the R/I/J single-datapath CPU: sequences IF/ID/EX/MEM/WB,
// drives every datapath enable and select, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int JAL_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             mem_write,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             ext_sign,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // The datapath hardwires $31 behind reg_dst=2; a different index needs a datapath change.
  if (JAL_REG != 31) begin : g_jal_reg_nonstandard
  end

  logic [2:0] state_reg, state_next;
  logic       is_r, is_sll, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_legal;
  logic [3:0] dec_alu_op;
  logic       dec_ext;
  logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;
  logic       illegal_raw, done_raw, en;

  // Instruction decode from the live IR fields.
  always_comb begin
    is_r = 1'b0; is_sll = 1'b0; is_imm = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0;
    dec_alu_op = 4'd0;
    dec_ext    = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin is_r = 1'b1; dec_alu_op = 4'd0; end
          6'h22: begin is_r = 1'b1; dec_alu_op = 4'd1; end
          6'h24: begin is_r = 1'b1; dec_alu_op = 4'd2; end
          6'h25: begin is_r = 1'b1; dec_alu_op = 4'd3; end
          6'h26: begin is_r = 1'b1; dec_alu_op = 4'd4; end
          6'h27: begin is_r = 1'b1; dec_alu_op = 4'd5; end
          6'h2A: begin is_r = 1'b1; dec_alu_op = 4'd6; end
          6'h00: begin is_sll = 1'b1; dec_alu_op = 4'd8; end
          default: ;
        endcase
      end
      6'h08: begin is_imm = 1'b1; dec_alu_op = 4'd0; dec_ext = 1'b1; end
      6'h0B: begin is_imm = 1'b1; dec_alu_op = 4'd7; dec_ext = 1'b1; end
      6'h0C: begin is_imm = 1'b1; dec_alu_op = 4'd2; end
      6'h0D: begin is_imm = 1'b1; dec_alu_op = 4'd3; end
      6'h0E: begin is_imm = 1'b1; dec_alu_op = 4'd4; end
      6'h23: begin is_lw  = 1'b1; dec_ext = 1'b1; end
      6'h2B: begin is_sw  = 1'b1; dec_ext = 1'b1; end
      6'h04: begin is_beq = 1'b1; dec_alu_op = 4'd1; dec_ext = 1'b1; end
      6'h05: begin is_bne = 1'b1; dec_alu_op = 4'd1; dec_ext = 1'b1; end
      6'h02: is_j   = 1'b1;
      6'h03: is_jal = 1'b1;
      default: ;
    endcase
  end

  assign is_legal = is_r | is_sll | is_imm | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IF;
    end else if (run) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF:  state_next = S_ID;
      S_ID: begin
        if (!is_legal || is_j) state_next = S_IF;
        else if (is_jal)       state_next = S_WB;
        else                   state_next = S_EX;
      end
      S_EX: begin
        if (is_lw || is_sw)        state_next = S_MEM;
        else if (is_beq || is_bne) state_next = S_IF;
        else                       state_next = S_WB;
      end
      S_MEM: state_next = is_lw ? S_WB : S_IF;
      default: state_next = S_IF;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    done_raw      = 1'b0;
    pc_src        = 2'd0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 4'd0;
    ext_sign      = 1'b0;
    case (state_reg)
      S_IF: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
      end
      S_ID: begin
        if (is_j) begin
          pc_write_raw = 1'b1;
          pc_src       = 2'd2;
          done_raw     = 1'b1;
        end else if (!is_legal) begin
          illegal_raw = 1'b1;
          done_raw    = 1'b1;
        end
      end
      S_EX: begin
        alu_op   = dec_alu_op;
        ext_sign = dec_ext;
        if (is_sll)                          alu_src_b = 2'd2;
        else if (is_imm || is_lw || is_sw)   alu_src_b = 2'd1;
        if (is_beq || is_bne) begin
          pc_src       = 2'd1;
          pc_write_raw = is_beq ? zero : ~zero;
          done_raw     = 1'b1;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_write_raw = 1'b1;
          done_raw      = 1'b1;
        end
      end
      S_WB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        if (is_r || is_sll) begin
          reg_dst = 2'd1;
        end else if (is_jal) begin
          reg_dst      = 2'd2;
          mem_to_reg   = 2'd2;
          pc_write_raw = 1'b1;
          pc_src       = 2'd2;
        end else if (is_lw) begin
          mem_to_reg = 2'd1;
        end
      end
      default: ;
    endcase
  end

  // A stalled or resetting controller must never write state or report completion.
  assign en         = run & rst_n;
  assign pc_write   = pc_write_raw  & en;
  assign ir_write   = ir_write_raw  & en;
  assign reg_write  = reg_write_raw & en;
  assign mem_write  = mem_write_raw & en;
  assign illegal    = illegal_raw   & en;
  assign instr_done = done_raw      & en;
  assign state      = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (instr_done) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
